// File: rtl/ipt_capture.sv
// Phase-gated round-robin channel sampler feeding a first-word-fall-through capture FIFO.
// A push is visible at the output one cycle later; when the FIFO is full, a capture is dropped unless a pop happens in the same cycle, and a drop sets the sticky overflow flag.
module ipt_capture #(
  parameter  int DW    = 4,
  parameter  int NCH   = 2,
  parameter  int PW    = 3,
  parameter  int DEPTH = 4,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [(1<<PW)-1:0]  cap_mask,
  input  logic [NCH*DW-1:0]   din,
  input  logic                clr_ovf,
  input  logic                out_ready,
  output logic [PW-1:0]       phase,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic [CW-1:0]       out_ch,
  output logic [AW:0]         count,
  output logic                overflow
);

  logic [PW-1:0]      r_phase;
  logic [CW-1:0]      r_ch_ptr;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_count;
  logic               r_ovf;
  logic [CW+DW-1:0]   r_mem [DEPTH];

  logic               w_cap;
  logic               w_pop;
  logic               w_full;
  logic               w_push;
  logic               w_drop;
  logic [DW-1:0]      w_sample;
  logic [CW+DW-1:0]   w_head;

  assign w_cap  = enable & cap_mask[r_phase];
  assign w_pop  = (r_count != '0) & out_ready;
  assign w_full = (r_count == (AW+1)'(DEPTH));
  // A full FIFO still accepts the capture when the head leaves in the same cycle.
  assign w_push = w_cap & (~w_full | w_pop);
  assign w_drop = w_cap & w_full & ~w_pop;

  always_comb begin
    w_sample = '0;
    for (int k = 0; k < NCH; k++) begin
      if (r_ch_ptr == CW'(k)) w_sample = din[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= '0;
      r_ch_ptr <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (enable) r_phase <= r_phase + 1'b1;
      // The channel pointer advances on every capture, accepted or dropped.
      if (w_cap) begin
        if (r_ch_ptr == CW'(NCH-1)) r_ch_ptr <= '0;
        else                        r_ch_ptr <= r_ch_ptr + 1'b1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wptr] <= {r_ch_ptr, w_sample};
  end

  assign w_head    = r_mem[r_rptr];
  assign phase     = r_phase;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? w_head[DW-1:0]     : '0;
  assign out_ch    = out_valid ? w_head[CW+DW-1:DW] : '0;

endmodule
